// File: rtl/cbw_pkg.sv
// Shared types and default geometry for the camera write path.
// The SDRAM controller and VGA read side import the same defaults.
package cbw_pkg;

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   localparam int PIX_W         = 16;       // RGB565
   localparam int DEF_BURST     = 8;        // words per SDRAM write burst
   localparam int DEF_FRAME_PIX = 307200;   // 640x480
   localparam int DEF_ADDR_W    = 22;       // SDRAM word address width

endpackage

// File: rtl/cbw_fifo.sv
// Single-clock first-word-fall-through pixel FIFO with flush.
// A push while full is still taken when the same cycle pops; a flush
// empties the FIFO and, if pushing, leaves the new word as sole entry.
module cbw_fifo
   import cbw_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = PIX_W
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic          full, empty, do_push, do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (flush || !full || do_pop);
   assign drop    = push && !do_push;

   // Head is shown combinationally; an empty FIFO presents zero
   assign dout = empty ? '0 : mem[rptr];

   // Storage write; a flushing push lands in slot 0
   always_ff @(posedge CLK) begin
      if (do_push)
         mem[flush ? '0 : wptr] <= din;
   end

   // Pointers and occupancy
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else if (flush) begin
         rptr  <= '0;
         wptr  <= do_push ? PW'(1) : '0;
         level <= do_push ? LW'(1) : '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/cmos_burst_writer.sv
// Camera pixel to SDRAM burst writer: buffers RGB565 pixels, requests
// fixed-length write bursts at frame-relative addresses, wraps per frame.
module cmos_burst_writer
   import cbw_pkg::*;
#(
   parameter int                BURST      = DEF_BURST,
   parameter int                FIFO_DEPTH = 16,
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
   parameter int                FRAME_PIX  = DEF_FRAME_PIX
) (
   input  logic                        CLK,
   input  logic                        RSTn,
   input  logic                        pix_valid,
   input  logic [PIX_W-1:0]            pix_data,
   input  logic                        pix_sof,
   output logic                        wr_req,
   output logic [ADDR_W-1:0]           wr_addr,
   input  logic                        wr_ack,
   input  logic                        wr_rd,
   output logic [PIX_W-1:0]            wr_data,
   output logic                        frame_done,
   output logic                        ovf,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int                LW        = $clog2(FIFO_DEPTH) + 1;
   localparam int                BW        = $clog2(BURST) + 1;
   localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST);
   localparam logic [ADDR_W-1:0] FRAME_END = BASE_ADDR + ADDR_W'(FRAME_PIX);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_cnt, addr_nx;
   logic [BW-1:0]     beat_cnt, beat_nx;
   logic              sof_pend, sof_pend_nx, frame_done_nx;
   logic              sof, flush, pop, burst_end, drop;

   // A new frame outside a transfer restarts buffering; inside a transfer
   // it is deferred so the granted burst still completes intact.
   assign sof       = pix_valid && pix_sof;
   assign flush     = sof && (state != XFER);
   assign pop       = (state == XFER) && wr_rd && (beat_cnt < BW'(BURST));
   assign burst_end = pop && (beat_cnt == BW'(BURST - 1));

   assign wr_req  = (state == REQ);
   assign wr_addr = addr_cnt;

   cbw_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .flush (flush),
      .push  (pix_valid),
      .din   (pix_data),
      .pop   (pop),
      .dout  (wr_data),
      .level (fifo_level),
      .drop  (drop)
   );

   // Next-state, beat counting and burst-end address update
   always_comb begin
      state_nx      = state;
      addr_nx       = addr_cnt;
      beat_nx       = beat_cnt;
      sof_pend_nx   = sof_pend;
      frame_done_nx = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               addr_nx     = BASE_ADDR;
               sof_pend_nx = 1'b0;
            end else if (fifo_level >= LW'(BURST)) begin
               state_nx = REQ;
            end
         end
         REQ: begin
            // sof wins over a same-cycle ack: the request is withdrawn
            if (flush) begin
               addr_nx     = BASE_ADDR;
               sof_pend_nx = 1'b0;
               state_nx    = IDLE;
            end else if (wr_ack) begin
               state_nx = XFER;
               beat_nx  = '0;
            end
         end
         XFER: begin
            if (sof) sof_pend_nx = 1'b1;
            if (pop) beat_nx = beat_cnt + 1'b1;
            if (burst_end) begin
               state_nx = IDLE;
               // an sof landing on the final beat counts as pending too
               if (sof_pend || sof) begin
                  addr_nx     = BASE_ADDR;
                  sof_pend_nx = 1'b0;
               end else if (addr_cnt + BURST_A == FRAME_END) begin
                  addr_nx       = BASE_ADDR;
                  frame_done_nx = 1'b1;
               end else begin
                  addr_nx = addr_cnt + BURST_A;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State, counters and sticky overflow
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state      <= IDLE;
         addr_cnt   <= BASE_ADDR;
         beat_cnt   <= '0;
         sof_pend   <= 1'b0;
         frame_done <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         state      <= state_nx;
         addr_cnt   <= addr_nx;
         beat_cnt   <= beat_nx;
         sof_pend   <= sof_pend_nx;
         frame_done <= frame_done_nx;
         ovf        <= ovf | drop;
      end
   end

endmodule

// File: tb/tb_cmos_burst_writer.sv
// Scoreboard bench for cmos_burst_writer with a 64-pixel frame.
module tb_cmos_burst_writer;
   import cbw_pkg::*;

   localparam int AW = 22;
   localparam int BL = 8;

   logic          CLK = 1'b0, RSTn = 1'b0;
   logic          pix_valid = 1'b0, pix_sof = 1'b0, wr_ack = 1'b0, wr_rd = 1'b0;
   logic [15:0]   pix_data = '0;
   logic          wr_req, frame_done, ovf;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic [4:0]    fifo_level;

   int            total = 0, bad = 0;
   logic [AW-1:0] exp_addr [$];
   logic [15:0]   exp_data [$];
   int            fd_expected = 0;
   bit            auto_ctl = 1'b0;
   int            rd_left = 0;

   cmos_burst_writer #(.BURST(BL), .FIFO_DEPTH(16), .ADDR_W(AW),
                       .BASE_ADDR('0), .FRAME_PIX(64)) dut (
      .CLK(CLK), .RSTn(RSTn), .pix_valid(pix_valid), .pix_data(pix_data),
      .pix_sof(pix_sof), .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
      .wr_rd(wr_rd), .wr_data(wr_data), .frame_done(frame_done), .ovf(ovf),
      .fifo_level(fifo_level));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(input logic [15:0] d, input bit sof);
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = sof;
      tick();
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic expect_burst(input logic [AW-1:0] a, input logic [15:0] d0, input int n);
      exp_addr.push_back(a);
      for (int k = 0; k < n; k++) exp_data.push_back(d0 + 16'(k));
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_addr.size() != 0 || exp_data.size() != 0) && n < 400) begin
         tick();
         n++;
      end
      total++;
      if (exp_addr.size() != 0 || exp_data.size() != 0) begin
         bad++;
         $display("FAIL %s: timeout with %0d addr %0d words left, want 0 0",
                  name, exp_addr.size(), exp_data.size());
      end
      tick();
      tick();
   endtask

   task automatic wait_ack_at(input string name, input logic [AW-1:0] a);
      int n;
      n = 0;
      while (!(wr_ack && wr_addr == a) && n < 100) begin
         tick();
         n++;
      end
      chk(name, {31'b0, wr_ack}, 32'd1);
   endtask

   // Simple SDRAM-side model: ack a request, then pull BURST words
   always begin
      @(posedge CLK);
      #2;
      if (!RSTn) begin
         rd_left = 0;
         if (auto_ctl) begin
            wr_ack = 1'b0;
            wr_rd  = 1'b0;
         end
      end else if (auto_ctl) begin
         wr_ack = 1'b0;
         wr_rd  = 1'b0;
         if (rd_left > 0) begin
            wr_rd = 1'b1;
            rd_left--;
         end else if (wr_req) begin
            wr_ack  = 1'b1;
            rd_left = BL;
         end
      end
   end

   // Monitor: compare accepted requests, read words and frame pulses
   always @(negedge CLK) begin
      if (RSTn) begin
         if (wr_req && wr_ack && !(pix_valid && pix_sof)) begin
            if (exp_addr.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_req: got addr %0h want no request", wr_addr);
            end else chk("burst_addr", 32'(wr_addr), 32'(exp_addr.pop_front()));
         end
         if (wr_rd) begin
            if (exp_data.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_word: got %0h want no read", wr_data);
            end else chk("burst_word", 32'(wr_data), 32'(exp_data.pop_front()));
         end
         if (frame_done) begin
            total++;
            if (fd_expected > 0) fd_expected--;
            else begin
               bad++;
               $display("FAIL frame_done: got pulse want none");
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values
      tick(); tick();
      RSTn = 1'b1;
      tick();
      chk("rst_wr_req", {31'b0, wr_req}, 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
      chk("rst_frame_done", {31'b0, frame_done}, 0);
      chk("rst_ovf", {31'b0, ovf}, 0);
      chk("rst_level", 32'(fifo_level), 0);

      // ---- 1: first burst, request latency and FWFT order
      for (int i = 0; i < 8; i++) push(16'(i + 1), 1'b0);
      chk("t1_level8", 32'(fifo_level), 8);
      chk("t1_req_not_yet", {31'b0, wr_req}, 0);
      chk("t1_head", 32'(wr_data), 16'h0001);
      tick();
      chk("t1_req", {31'b0, wr_req}, 1);
      chk("t1_addr", 32'(wr_addr), 0);
      expect_burst(0, 16'h0001, 8);
      auto_ctl = 1'b1;
      wait_drain("t1_drain");
      chk("t1_next_addr", 32'(wr_addr), 8);
      chk("t1_level0", 32'(fifo_level), 0);

      // ---- 2: whole 64-pixel frame, wraps with one frame_done
      fd_expected = 1;
      for (int b = 0; b < 8; b++) expect_burst(AW'(b * 8), 16'h0100 + 16'(b * 8), 8);
      for (int i = 0; i < 64; i++) begin
         push(16'h0100 + 16'(i), i == 0);
         tick();
      end
      expect_burst(0, 16'h0200, 8);
      for (int i = 0; i < 8; i++) begin
         push(16'h0200 + 16'(i), 1'b0);
         tick();
      end
      wait_drain("t2_drain");
      chk("t2_frame_done_seen", 32'(fd_expected), 0);
      chk("t2_next_addr", 32'(wr_addr), 8);

      // ---- 5: sof during the burst at 24 -> next burst restarts at 0
      expect_burst(8, 16'h0300, 8);
      expect_burst(16, 16'h0308, 8);
      expect_burst(24, 16'h0310, 8);
      for (int i = 0; i < 24; i++) begin
         push(16'h0300 + 16'(i), 1'b0);
         tick();
      end
      wait_ack_at("t5_ack24", 24);
      expect_burst(0, 16'h5A5A, 8);
      push(16'h5A5A, 1'b1);
      for (int i = 1; i < 8; i++) begin
         tick();
         push(16'h5A5A + 16'(i), 1'b0);
      end
      wait_drain("t5_drain");
      chk("t5_next_addr", 32'(wr_addr), 8);

      // ---- 3: controller stalls, FIFO saturates, sticky overflow
      auto_ctl = 1'b0;
      for (int i = 0; i < 20; i++) begin
         push(16'h0400 + 16'(i), 1'b0);
         if (i == 15) begin
            chk("t3_level16", 32'(fifo_level), 16);
            chk("t3_no_ovf_at16", {31'b0, ovf}, 0);
         end
         if (i == 16) chk("t3_ovf_at17", {31'b0, ovf}, 1);
      end
      chk("t3_level_sat", 32'(fifo_level), 16);
      chk("t3_req_held", {31'b0, wr_req}, 1);
      expect_burst(8, 16'h0400, 8);
      expect_burst(16, 16'h0408, 8);
      auto_ctl = 1'b1;
      wait_drain("t3_drain");
      chk("t3_ovf_sticky", {31'b0, ovf}, 1);
      chk("t3_level0", 32'(fifo_level), 0);

      // ---- 4: sof while a request is pending (with a same-cycle ack)
      auto_ctl = 1'b0;
      for (int i = 0; i < 8; i++) push(16'h0500 + 16'(i), 1'b0);
      tick();
      chk("t4_req_pending", {31'b0, wr_req}, 1);
      chk("t4_req_addr", 32'(wr_addr), 24);
      pix_valid = 1'b1; pix_sof = 1'b1; pix_data = 16'hABCD; wr_ack = 1'b1;
      tick();
      pix_valid = 1'b0; pix_sof = 1'b0; wr_ack = 1'b0;
      chk("t4_level1", 32'(fifo_level), 1);
      chk("t4_req_drop", {31'b0, wr_req}, 0);
      chk("t4_head", 32'(wr_data), 16'hABCD);
      tick();
      chk("t4_still_idle", {31'b0, wr_req}, 0);
      exp_addr.push_back(0);
      exp_data.push_back(16'hABCD);
      for (int k = 0; k < 7; k++) exp_data.push_back(16'h0510 + 16'(k));
      auto_ctl = 1'b1;
      for (int i = 0; i < 7; i++) push(16'h0510 + 16'(i), 1'b0);
      wait_drain("t4_drain");

      // ---- 6: reset during beat 3 of a transfer
      chk("t6_ovf_before_rst", {31'b0, ovf}, 1);
      expect_burst(8, 16'h0600, 3);
      for (int i = 0; i < 8; i++) push(16'h0600 + 16'(i), 1'b0);
      wait_ack_at("t6_ack8", 8);
      tick(); tick(); tick();
      RSTn = 1'b0;
      #1;
      chk("t6_wr_req", {31'b0, wr_req}, 0);
      chk("t6_wr_addr", 32'(wr_addr), 0);
      chk("t6_wr_data", 32'(wr_data), 0);
      chk("t6_frame_done", {31'b0, frame_done}, 0);
      chk("t6_ovf", {31'b0, ovf}, 0);
      chk("t6_level", 32'(fifo_level), 0);
      tick(); tick();
      RSTn = 1'b1;
      chk("t6_beats_before_rst", 32'(exp_data.size()), 0);
      tick();
      expect_burst(0, 16'h0700, 8);
      for (int i = 0; i < 8; i++) push(16'h0700 + 16'(i), 1'b0);
      wait_drain("t6_drain");
      chk("t6_next_addr", 32'(wr_addr), 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
